elevator_ctrl_n: RTL

Parametrised N-floor elevator controller using SCAN scheduling. It is the successor to the fixed 3-floor mealy/moore elevators. Per-floor call requests are latched into a pending register, and the car moves one floor per TRAVEL_CYCLES. The door opens for DOOR_CYCLES at each serviced floor, and the current direction is held while requests remain ahead. It sits between the floor-button front end and the motor/door drivers.

---
 rtl/elevator_pkg.sv | 27 ++
 rtl/elevator_req_scan.sv | 31 +++
 rtl/elevator_ctrl_n.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/elevator_pkg.sv
// Shared types and helpers for the N-floor SCAN elevator controller.
package elevator_pkg;

    // Controller state; outputs are decoded directly from this.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR      = 2'd3
    } state_t;

    // Direction remembered across stops so SCAN keeps sweeping the same way.
    typedef enum logic {
        UP = 1'b0,
        DN = 1'b1
    } dir_t;

    // Width needed to index 0..n-1; never returns zero so n=1 counters stay legal.
    function automatic int floor_w(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/elevator_req_scan.sv
// Looks at the latched calls relative to the car: anything above, anything
// below, and whether the current floor itself is called.
module elevator_req_scan
    import elevator_pkg::*;
#(
    parameter int FLOORS = 4
) (
    input  logic [FLOORS-1:0]          pending,
    input  logic [floor_w(FLOORS)-1:0] cur_floor,
    output logic                       ahead_up,
    output logic                       ahead_dn,
    output logic                       here
);

    // Reduce every call bit into above / below / here relative to the car.
    always_comb begin
        ahead_up = 1'b0;
        ahead_dn = 1'b0;
        here     = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (i > int'(cur_floor)) begin
                ahead_up = ahead_up | pending[i];
            end else if (i < int'(cur_floor)) begin
                ahead_dn = ahead_dn | pending[i];
            end else begin
                here = pending[i];
            end
        end
    end

endmodule

// File: rtl/elevator_ctrl_n.sv
// N-floor elevator controller with SCAN scheduling: latches floor calls,
// sweeps in one direction while calls remain ahead, opens the door at each
// called floor. All outputs come from registers only.
module elevator_ctrl_n
    import elevator_pkg::*;
#(
    parameter int FLOORS        = 4,
    parameter int DOOR_CYCLES   = 3,
    parameter int TRAVEL_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [FLOORS-1:0]          req,
    output logic [floor_w(FLOORS)-1:0] cur_floor,
    output logic                       dir_up,
    output logic                       dir_down,
    output logic                       door_open,
    output logic                       idle,
    output logic                       arrive,
    output logic [FLOORS-1:0]          pending
);

    localparam int FW  = floor_w(FLOORS);
    localparam int DCW = floor_w(DOOR_CYCLES);
    localparam int TCW = floor_w(TRAVEL_CYCLES);

    localparam logic [FW-1:0]     TOP_FLOOR   = FW'(FLOORS - 1);
    localparam logic [DCW-1:0]    DOOR_RELOAD = DCW'(DOOR_CYCLES - 1);
    localparam logic [TCW-1:0]    TRAV_RELOAD = TCW'(TRAVEL_CYCLES - 1);
    localparam logic [FLOORS-1:0] BIT0        = {{(FLOORS-1){1'b0}}, 1'b1};

    state_t            state_r,     state_s;
    dir_t              last_dir_r,  last_dir_s;
    logic [FW-1:0]     cur_floor_r, floor_s;
    logic [FLOORS-1:0] pending_r,   pending_s;
    logic [DCW-1:0]    door_cnt_r,  door_cnt_s;
    logic [TCW-1:0]    trav_cnt_r,  trav_cnt_s;
    logic              arrive_r,    arrive_s;
    logic [FLOORS-1:0] clr_s;
    logic [FW-1:0]     floor_up_s,  floor_dn_s;
    logic              ahead_up_s,  ahead_dn_s, here_s;
    logic              fwd_s,       rev_s;

    elevator_req_scan #(.FLOORS(FLOORS)) u_scan (
        .pending   (pending_r),
        .cur_floor (cur_floor_r),
        .ahead_up  (ahead_up_s),
        .ahead_dn  (ahead_dn_s),
        .here      (here_s)
    );

    assign floor_up_s = cur_floor_r + FW'(1);
    assign floor_dn_s = cur_floor_r - FW'(1);
    // Calls ahead in the remembered direction, and behind it.
    assign fwd_s      = (last_dir_r == UP) ? ahead_up_s : ahead_dn_s;
    assign rev_s      = (last_dir_r == UP) ? ahead_dn_s : ahead_up_s;

    // Next-state, timer and call-mask decisions; FSM reads registered calls only.
    always_comb begin
        state_s    = state_r;
        floor_s    = cur_floor_r;
        last_dir_s = last_dir_r;
        door_cnt_s = door_cnt_r;
        trav_cnt_s = trav_cnt_r;
        arrive_s   = 1'b0;
        clr_s      = {FLOORS{1'b0}};
        case (state_r)
            IDLE: begin
                if (here_s) begin
                    state_s    = DOOR;
                    door_cnt_s = DOOR_RELOAD;
                    clr_s      = BIT0 << cur_floor_r;
                end else if (fwd_s || rev_s) begin
                    // Both-ahead case resolves to the remembered direction.
                    if ((last_dir_r == UP) == fwd_s) begin
                        state_s    = MOVE_UP;
                        last_dir_s = UP;
                    end else begin
                        state_s    = MOVE_DOWN;
                        last_dir_s = DN;
                    end
                    trav_cnt_s = TRAV_RELOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            MOVE_UP, MOVE_DOWN: begin
                if (trav_cnt_r != {TCW{1'b0}}) begin
                    trav_cnt_s = trav_cnt_r - TCW'(1);
                end else begin
                    floor_s  = (state_r == MOVE_UP) ? floor_up_s : floor_dn_s;
                    arrive_s = 1'b1;
                    if (pending_r[floor_s]) begin
                        state_s    = DOOR;
                        door_cnt_s = DOOR_RELOAD;
                        clr_s      = BIT0 << floor_s;
                    end else if ((floor_s == TOP_FLOOR) || (floor_s == {FW{1'b0}})) begin
                        // Unreachable while a call ahead exists; never drive past an end stop.
                        state_s = IDLE;
                    end else begin
                        trav_cnt_s = TRAV_RELOAD;
                    end
                end
            end
            DOOR: begin
                // Calls for this floor are absorbed while the door is open.
                clr_s = BIT0 << cur_floor_r;
                if (req[cur_floor_r]) begin
                    door_cnt_s = DOOR_RELOAD;
                end else if (door_cnt_r != {DCW{1'b0}}) begin
                    door_cnt_s = door_cnt_r - DCW'(1);
                end else if (fwd_s || rev_s) begin
                    if ((last_dir_r == UP) == fwd_s) begin
                        state_s    = MOVE_UP;
                        last_dir_s = UP;
                    end else begin
                        state_s    = MOVE_DOWN;
                        last_dir_s = DN;
                    end
                    trav_cnt_s = TRAV_RELOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        pending_s = (pending_r | req) & ~clr_s;
    end

    // State, position, call latch and timers; reset parks the car at floor 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            last_dir_r  <= UP;
            cur_floor_r <= {FW{1'b0}};
            pending_r   <= {FLOORS{1'b0}};
            door_cnt_r  <= {DCW{1'b0}};
            trav_cnt_r  <= {TCW{1'b0}};
            arrive_r    <= 1'b0;
        end else begin
            state_r     <= state_s;
            last_dir_r  <= last_dir_s;
            cur_floor_r <= floor_s;
            pending_r   <= pending_s;
            door_cnt_r  <= door_cnt_s;
            trav_cnt_r  <= trav_cnt_s;
            arrive_r    <= arrive_s;
        end
    end

    assign cur_floor = cur_floor_r;
    assign pending   = pending_r;
    assign arrive    = arrive_r;
    assign dir_up    = (state_r == MOVE_UP);
    assign dir_down  = (state_r == MOVE_DOWN);
    assign door_open = (state_r == DOOR);
    assign idle      = (state_r == IDLE);

endmodule
